maa_share_arb: RTL and testbench
================================

MAA_SHARE_ARB -- requirements
Module: maa_share_arb

Interface
REQ-001 Parameters SHALL be, one per line:
- LOG2_WIDTH, 4, log2 of operand width.
- WIDTH, 2**LOG2_WIDTH, operand width.
- NREQ, 4, number of requesters (2..8).
- OPW, LOG2_WIDTH+WIDTH-1, adder operand width.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- rst_n, in, 1, reset, synchronous, active-low.
- en, in, 1, grant enable; low blocks new grants.
- req_valid, in, NREQ, per-requester valid.
- req_ready, out, NREQ, per-requester ready.
- req_op1, in, NREQ*OPW, packed operand 1, requester i at [i*OPW +: OPW].
- req_op2, in, NREQ*OPW, packed operand 2, same packing.
- add_op1, out, OPW, operand 1 to the external combinational adder.
- add_op2, out, OPW, operand 2 to the external combinational adder.
- add_x, in, WIDTH-1, adder fraction result.
- add_k, in, LOG2_WIDTH+1, adder characteristic result.
- rsp_valid, out, 1, response valid.
- rsp_ready, in, 1, response ready.
- rsp_id, out, clog2(NREQ), requester index of the response.
- rsp_x, out, WIDTH-1, registered add_x.
- rsp_k, out, LOG2_WIDTH+1, registered add_k.

Function
REQ-003 The block SHALL time-share one external adder among NREQ requesters, with at most one grant per cycle.
REQ-004 Arbitration SHALL be round-robin: search starts at last_grant+1 mod NREQ; after reset, last_grant = NREQ-1.
REQ-005 Free condition: can_issue = en & (~rsp_valid | rsp_ready).
REQ-006 Grant rule: grant[i] = 1 only for the round-robin winner among req_valid, and only when can_issue = 1.
REQ-007 req_ready[i] SHALL equal grant[i] combinationally; a transfer occurs when req_valid[i] & req_ready[i].
REQ-008 add_op1 and add_op2 SHALL carry the winner's operands combinationally; when there is no winner, both SHALL be 0.
REQ-009 On a transfer, the next edge SHALL load rsp_x, rsp_k and rsp_id, set rsp_valid, and set last_grant to the winner; latency is 1 cycle.
REQ-010 FSM states SHALL be EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- EMPTY -> FULL on a transfer.
- FULL -> EMPTY on rsp_ready with no transfer.
- FULL -> FULL on rsp_ready with a transfer (back-to-back, full throughput).
- FULL with rsp_ready=0 SHALL hold all rsp_* stable.
REQ-011 When en falls, no new grant SHALL issue; a FULL response still drains normally.
REQ-012 A requester's valid dropping without a transfer SHALL NOT affect last_grant.

Reset
REQ-013 When rst_n=0 at an edge: rsp_valid=0, rsp_x=0, rsp_k=0, rsp_id=0, last_grant=NREQ-1, state EMPTY, stats counters=0.
REQ-014 During reset, req_ready SHALL be 0; reset mid-transaction SHALL discard the in-flight response without emitting it.

Configuration
REQ-015 Macro MAA_SHARE_STATS_EN.
- Defined: adds output stat_busy (32 bits), counting cycles with a transfer, and output stat_stall (32 bits), counting cycles with rsp_valid & ~rsp_ready. Both saturate at all-ones and are cleared by reset.
- Undefined: these ports and counters SHALL be absent, and all other behaviour is unchanged.

Structure
REQ-016 Shared package maa_pkg SHALL hold the default LOG2_WIDTH, WIDTH, NREQ and OPW, the state enum {EMPTY, FULL}, and the id width function.
REQ-017 Round-robin selection SHALL be one sub-module, rr_arb (inputs: req, last, en; outputs: grant one-hot, gnt_id, any).

Verification
REQ-018 The bench SHALL pair the block with a golden adder model:
- sum[7:0] = op2[7:0]
- sum[19:8] = op1[18:8] + op2[18:8] + op1[7]
- x = sum[14:0], k = sum[19:15]

REQ-019 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Single request, req0 with op1=0x00080, op2=0x00100, rsp_ready=1 -> one cycle later rsp_valid=1, rsp_id=0, rsp_x=0x0200, rsp_k=0.
- All four requesters valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0 on consecutive cycles, one response per cycle.
- rsp_ready=0 for 3 cycles while FULL -> rsp_* held stable; req_ready all 0; transfer resumes the cycle rsp_ready returns to 1.
- en=0 while FULL and req1 valid -> existing response drains; no grant until en=1.
- rst_n=0 for one cycle while FULL -> rsp_valid=0 next cycle; the next grant goes to requester 0 first.
- With MAA_SHARE_STATS_EN: 10 transfers and 3 stall cycles -> stat_busy=10, stat_stall=3.

Source files
------------

// File: rtl/maa_pkg.sv
// Shared defaults, response-slot state encoding and id-width helper for maa_share_arb.
package maa_pkg;

    localparam int DEF_LOG2_WIDTH = 4;
    localparam int DEF_WIDTH      = 2**DEF_LOG2_WIDTH;
    localparam int DEF_NREQ       = 4;
    localparam int DEF_OPW        = DEF_LOG2_WIDTH + DEF_WIDTH - 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int id_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin selector: searches from last+1 (mod NREQ) and returns a one-hot grant,
// its index and an any-grant flag. Nothing is granted while en is low.
module rr_arb
    import maa_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int IDW  = id_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);

    // NOTE: every output gets a default before the search loop, so no latch is inferred.
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        any    = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(last) + k) % NREQ;
            if (en && !any && req[idx]) begin
                grant[idx] = 1'b1;
                gnt_id     = IDW'(idx);
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/maa_share_arb.sv
// Time-shares one external combinational adder among NREQ requesters with a
// one-entry response register. Optional counters: define MAA_SHARE_STATS_EN.
module maa_share_arb
    import maa_pkg::*;
#(
    parameter  int LOG2_WIDTH = DEF_LOG2_WIDTH,
    parameter  int WIDTH      = 2**LOG2_WIDTH,
    parameter  int NREQ       = DEF_NREQ,
    parameter  int OPW        = LOG2_WIDTH + WIDTH - 1,
    localparam int IDW        = id_w(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*OPW-1:0] req_op1,
    input  logic [NREQ*OPW-1:0] req_op2,
    output logic [OPW-1:0]      add_op1,
    output logic [OPW-1:0]      add_op2,
    input  logic [WIDTH-2:0]    add_x,
    input  logic [LOG2_WIDTH:0] add_k,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [WIDTH-2:0]    rsp_x,
    output logic [LOG2_WIDTH:0] rsp_k
`ifdef MAA_SHARE_STATS_EN
    ,
    output logic [31:0]         stat_busy,
    output logic [31:0]         stat_stall
`endif
);

    state_t          state, state_nxt;
    logic [IDW-1:0]  last_grant;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gnt_id;
    logic            can_issue;
    logic            xfer;

    assign rsp_valid = (state == FULL);

    // Reset is synchronous, so grants must be masked explicitly while rst_n is low.
    assign can_issue = rst_n & en & (~rsp_valid | rsp_ready);

    rr_arb #(.NREQ(NREQ)) u_rr_arb (
        .req    (req_valid),
        .last   (last_grant),
        .en     (can_issue),
        .grant  (grant),
        .gnt_id (gnt_id),
        .any    (xfer)
    );

    assign req_ready = grant;

    always_comb begin
        add_op1 = '0;
        add_op2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                add_op1 = req_op1[i*OPW +: OPW];
                add_op2 = req_op2[i*OPW +: OPW];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (xfer) state_nxt = FULL;
            FULL:    if (rsp_ready && !xfer) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= EMPTY;
            last_grant <= IDW'(NREQ - 1);
            rsp_id     <= '0;
            rsp_x      <= '0;
            rsp_k      <= '0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                last_grant <= gnt_id;
                rsp_id     <= gnt_id;
                rsp_x      <= add_x;
                rsp_k      <= add_k;
            end
        end
    end

`ifdef MAA_SHARE_STATS_EN
    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_busy  <= '0;
            stat_stall <= '0;
        end else begin
            if (xfer && (stat_busy != '1))
                stat_busy <= stat_busy + 32'd1;
            if (rsp_valid && !rsp_ready && (stat_stall != '1))
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_maa_share_arb.sv
// Self-checking bench for maa_share_arb: golden adder, behavioural reference model,
// directed vector table and randomized traffic.
module tb_maa_share_arb;
    import maa_pkg::*;

    localparam int LW  = DEF_LOG2_WIDTH;
    localparam int W   = DEF_WIDTH;
    localparam int N   = DEF_NREQ;
    localparam int OPW = DEF_OPW;
    localparam int IDW = id_w(DEF_NREQ);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*OPW-1:0] req_op1;
    logic [N*OPW-1:0] req_op2;
    logic [OPW-1:0]   add_op1;
    logic [OPW-1:0]   add_op2;
    logic [W-2:0]     add_x;
    logic [LW:0]      add_k;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [W-2:0]     rsp_x;
    logic [LW:0]      rsp_k;
`ifdef MAA_SHARE_STATS_EN
    logic [31:0]      stat_busy;
    logic [31:0]      stat_stall;
`endif

    always #5 clk = ~clk;

    maa_share_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op1   (req_op1),
        .req_op2   (req_op2),
        .add_op1   (add_op1),
        .add_op2   (add_op2),
        .add_x     (add_x),
        .add_k     (add_k),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_x     (rsp_x),
        .rsp_k     (rsp_k)
`ifdef MAA_SHARE_STATS_EN
        ,
        .stat_busy (stat_busy),
        .stat_stall(stat_stall)
`endif
    );

    // Per-requester operands, packed onto the DUT buses.
    logic [OPW-1:0] op1_a [N];
    logic [OPW-1:0] op2_a [N];

    always_comb begin
        req_op1 = '0;
        req_op2 = '0;
        for (int i = 0; i < N; i++) begin
            req_op1[i*OPW +: OPW] = op1_a[i];
            req_op2[i*OPW +: OPW] = op2_a[i];
        end
    end

    // Golden adder.
    function automatic logic [19:0] gsum(input logic [18:0] a, input logic [18:0] b);
        logic [19:0] s;
        s[7:0]  = b[7:0];
        s[19:8] = 12'(a[18:8]) + 12'(b[18:8]) + 12'(a[7]);
        return s;
    endfunction

    logic [19:0] add_sum;
    always_comb add_sum = gsum(add_op1, add_op2);
    assign add_x = add_sum[14:0];
    assign add_k = add_sum[19:15];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pending response slot plus the round-robin pointer.
    int         m_last;
    bit         m_valid;
    int         m_id;
    logic [14:0] m_x;
    logic [4:0]  m_k;
`ifdef MAA_SHARE_STATS_EN
    logic [31:0] m_busy;
    logic [31:0] m_stall;
`endif

    task automatic model_reset();
        m_last  = N - 1;
        m_valid = 1'b0;
        m_id    = 0;
        m_x     = '0;
        m_k     = '0;
`ifdef MAA_SHARE_STATS_EN
        m_busy  = '0;
        m_stall = '0;
`endif
    endtask

    // One clock cycle: drive at posedge+1, compare at negedge, advance model at posedge.
    task automatic do_cycle(input logic rn, input logic e, input logic [N-1:0] v, input logic rr,
                            output logic [N-1:0] got_ready, output logic got_rv,
                            output logic [IDW-1:0] got_id);
        int           w;
        bit           can;
        logic [N-1:0] exp_ready;
        logic [19:0]  s;
        rst_n     = rn;
        en        = e;
        req_valid = v;
        rsp_ready = rr;
        can = rn && e && (!m_valid || rr);
        w   = -1;
        if (can) begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_last + k) % N;
                if (w < 0 && v[idx]) w = idx;
            end
        end
        exp_ready = '0;
        if (w >= 0) exp_ready[w] = 1'b1;
        @(negedge clk);
        got_ready = req_ready;
        got_rv    = rsp_valid;
        got_id    = rsp_id;
        check("ready", 32'(req_ready), 32'(exp_ready));
        if (w >= 0) begin
            check("add_op1", 32'(add_op1), 32'(op1_a[w]));
            check("add_op2", 32'(add_op2), 32'(op2_a[w]));
        end else begin
            check("add_op1_idle", 32'(add_op1), 32'd0);
            check("add_op2_idle", 32'(add_op2), 32'd0);
        end
        check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        if (m_valid) begin
            check("rsp_id", 32'(rsp_id), 32'(m_id));
            check("rsp_x", 32'(rsp_x), 32'(m_x));
            check("rsp_k", 32'(rsp_k), 32'(m_k));
        end
`ifdef MAA_SHARE_STATS_EN
        check("stat_busy", stat_busy, m_busy);
        check("stat_stall", stat_stall, m_stall);
`endif
        @(posedge clk);
        if (!rn) begin
            model_reset();
        end else begin
`ifdef MAA_SHARE_STATS_EN
            if (w >= 0 && m_busy != 32'hffff_ffff) m_busy++;
            if (m_valid && !rr && m_stall != 32'hffff_ffff) m_stall++;
`endif
            if (w >= 0) begin
                s       = gsum(op1_a[w], op2_a[w]);
                m_valid = 1'b1;
                m_id    = w;
                m_x     = s[14:0];
                m_k     = s[19:15];
                m_last  = w;
            end else if (rr) begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    typedef struct {
        logic         en;
        logic [N-1:0] v;
        logic         rr;
        logic [N-1:0] exp_ready;
        logic         exp_rv;
        int           exp_id;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [N-1:0]   g_ready;
        logic           g_rv;
        logic [IDW-1:0] g_id;

        // Round-robin, stall, en-low drain; starts right after a reset.
        tbl[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b0, 0};
        tbl[1]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 0};
        tbl[2]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 1};
        tbl[3]  = '{1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 2};
        tbl[4]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 3};
        tbl[5]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1, 0};
        tbl[6]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1, 0};
        tbl[7]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1, 0};
        tbl[8]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 0};
        tbl[9]  = '{1'b0, 4'b0010, 1'b1, 4'b0000, 1'b1, 1};
        tbl[10] = '{1'b0, 4'b0010, 1'b1, 4'b0000, 1'b0, 0};
        tbl[11] = '{1'b0, 4'b0010, 1'b1, 4'b0000, 1'b0, 0};
        tbl[12] = '{1'b1, 4'b0010, 1'b1, 4'b0010, 1'b0, 0};
        tbl[13] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 1};

        for (int i = 0; i < N; i++) begin
            op1_a[i] = '0;
            op2_a[i] = '0;
        end
        rst_n = 1'b0; en = 1'b1; req_valid = '1; rsp_ready = 1'b1;

        // Initial reset with everything requesting: nothing may be granted.
        @(posedge clk); #1;
        model_reset();
        @(negedge clk);
        check("reset_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_x", 32'(rsp_x), 32'd0);
        check("reset_rsp_k", 32'(rsp_k), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        @(posedge clk); #1;

        // Single request from requester 0.
        op1_a[0] = 19'h00080;
        op2_a[0] = 19'h00100;
        do_cycle(1'b1, 1'b1, 4'b0001, 1'b1, g_ready, g_rv, g_id);
        check("single_ready", 32'(g_ready), 32'b0001);
        check("single_valid", 32'(rsp_valid), 32'd1);
        check("single_id", 32'(rsp_id), 32'd0);
        check("single_x", 32'(rsp_x), 32'h0200);
        check("single_k", 32'(rsp_k), 32'd0);
        do_cycle(1'b1, 1'b1, 4'b0000, 1'b1, g_ready, g_rv, g_id);
        do_cycle(1'b0, 1'b1, 4'b0000, 1'b1, g_ready, g_rv, g_id);

        for (int i = 0; i < N; i++) begin
            op1_a[i] = OPW'($urandom);
            op2_a[i] = OPW'($urandom);
        end
        for (int i = 0; i < 14; i++) begin
            do_cycle(1'b1, tbl[i].en, tbl[i].v, tbl[i].rr, g_ready, g_rv, g_id);
            check($sformatf("tbl%0d_ready", i), 32'(g_ready), 32'(tbl[i].exp_ready));
            check($sformatf("tbl%0d_rv", i), 32'(g_rv), 32'(tbl[i].exp_rv));
            if (tbl[i].exp_rv)
                check($sformatf("tbl%0d_id", i), 32'(g_id), 32'(tbl[i].exp_id));
        end

        // Reset while a response is pending: it is discarded and requester 0 wins next.
        do_cycle(1'b1, 1'b1, 4'b0100, 1'b0, g_ready, g_rv, g_id);
        check("mid_grant", 32'(g_ready), 32'b0100);
        do_cycle(1'b0, 1'b1, 4'b1111, 1'b0, g_ready, g_rv, g_id);
        check("mid_reset_ready", 32'(g_ready), 32'd0);
        check("mid_reset_was_full", 32'(g_rv), 32'd1);
        do_cycle(1'b1, 1'b1, 4'b1111, 1'b1, g_ready, g_rv, g_id);
        check("after_reset_rv", 32'(g_rv), 32'd0);
        check("after_reset_grant", 32'(g_ready), 32'b0001);

`ifdef MAA_SHARE_STATS_EN
        do_cycle(1'b0, 1'b1, 4'b0000, 1'b1, g_ready, g_rv, g_id);
        for (int i = 0; i < 10; i++)
            do_cycle(1'b1, 1'b1, 4'b0001, 1'b1, g_ready, g_rv, g_id);
        for (int i = 0; i < 3; i++)
            do_cycle(1'b1, 1'b1, 4'b0000, 1'b0, g_ready, g_rv, g_id);
        check("stats_busy10", stat_busy, 32'd10);
        check("stats_stall3", stat_stall, 32'd3);
`endif

        // Randomized traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                op1_a[i] = OPW'($urandom);
                op2_a[i] = OPW'($urandom);
            end
            do_cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), N'($urandom),
                     ($urandom_range(0, 2) != 0), g_ready, g_rv, g_id);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
